// File: rtl/sdram_request_arbiter.sv
// sdram_request_arbiter: round-robin single-word arbiter in front of one SDRAM controller
// optional watchdog enabled by SDRAM_ARB_TIMEOUT_EN
module sdram_request_arbiter #(
    parameter int NUM_PORTS      = 3,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    activeClock,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    req,
    input  logic [NUM_PORTS-1:0]    reqWrite,
    input  logic [25*NUM_PORTS-1:0] reqAddress,
    input  logic [16*NUM_PORTS-1:0] reqWriteData,
    output logic [NUM_PORTS-1:0]    done,
    output logic [15:0]             readData,
    output logic                    timeoutError,
    output logic [24:0]             sdram_address,
    output logic [15:0]             sdram_inputData,
    output logic                    sdram_isWriting,
    output logic                    sdram_inputValid,
    input  logic [15:0]             sdram_outputData,
    input  logic                    sdram_outputValid,
    input  logic                    sdram_isBusy,
    input  logic                    sdram_recievedCommand
);
    localparam int PW = $clog2(NUM_PORTS);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, DONE} state_t;
    state_t        state;
    logic [PW-1:0] last_grant, winner, pick;
    logic          found, settled, expired, complete;
    always_comb begin
        pick  = last_grant;
        found = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            if (!found && req[PW'((int'(last_grant) + i) % NUM_PORTS)]) begin
                pick  = PW'((int'(last_grant) + i) % NUM_PORTS);
                found = 1'b1;
            end
        end
    end
    // a write may not have raised isBusy yet on the first WAIT_DONE cycle
    assign complete = sdram_isWriting ? settled && !sdram_isBusy : sdram_outputValid;
    always_ff @(posedge activeClock) begin
        if (reset) begin
            state            <= IDLE;
            last_grant       <= PW'(NUM_PORTS - 1);
            winner           <= '0;
            settled          <= 1'b0;
            done             <= '0;
            readData         <= '0;
            sdram_address    <= '0;
            sdram_inputData  <= '0;
            sdram_isWriting  <= 1'b0;
            sdram_inputValid <= 1'b0;
        end else begin
            done <= '0;
            case (state)
                IDLE: if (found && !sdram_isBusy) begin
                    winner           <= pick;
                    sdram_address    <= reqAddress[25*pick +: 25];
                    sdram_inputData  <= reqWriteData[16*pick +: 16];
                    sdram_isWriting  <= reqWrite[pick];
                    sdram_inputValid <= 1'b1;
                    state            <= ISSUE;
                end
                ISSUE: if (expired || sdram_recievedCommand) begin
                    sdram_inputValid <= 1'b0;
                    settled          <= 1'b0;
                    done[winner]     <= expired;
                    state            <= expired ? DONE : WAIT_DONE;
                end
                WAIT_DONE: if (expired || complete) begin
                    if (!expired && !sdram_isWriting) readData <= sdram_outputData;
                    done[winner] <= 1'b1;
                    state        <= DONE;
                end else begin
                    settled <= 1'b1;
                end
                default: begin
                    last_grant <= winner;
                    state      <= IDLE;
                end
            endcase
        end
    end
`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [15:0] timer;
    logic        timed_out;
    assign expired      = (state == ISSUE || state == WAIT_DONE) && timer == 16'(TIMEOUT_CYCLES - 1);
    assign timeoutError = timed_out;
    always_ff @(posedge activeClock) begin
        timer     <= (reset || state == IDLE || state == DONE) ? '0 : timer + 16'd1;
        timed_out <= !reset && expired;
    end
`else
    assign expired      = 1'b0;
    assign timeoutError = 1'b0;
`endif
endmodule
